alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; SHALL match the shared ALU width.
REQ-002 Parameter CTRL_W, default 4, ALU_control width.
REQ-003 clk  input  1  system clock, all state on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  2  per-requester operation request, bit i = requester i.
REQ-006 req_ready  output  2  per-requester accept; at most one bit high.
REQ-007 req_src1  input  2*DATA_W  operand 1, slice i = requester i.
REQ-008 req_src2  input  2*DATA_W  operand 2, slice i = requester i.
REQ-009 req_ctrl  input  2*CTRL_W  ALU_control code, slice i = requester i.
REQ-010 alu_src1 / alu_src2  output  DATA_W  operands driven to the shared ALU.
REQ-011 alu_ctrl  output  CTRL_W  ALU_control driven to the shared ALU.
REQ-012 alu_result  input  DATA_W; alu_zero, alu_cout, alu_overflow  input  1  registered ALU outputs.
REQ-013 resp_valid  output  1  response held valid.
REQ-014 resp_ready  input  1  consumer accepts response.
REQ-015 resp_id  output  1  index of requester owning the response.
REQ-016 resp_result  output  DATA_W; resp_zero, resp_cout, resp_overflow  output  1  captured ALU outputs.

Function
REQ-017 FSM SHALL have states IDLE, EXEC, CAPT, RESP.
REQ-018 IDLE: req_ready SHALL be high only for the arbitration winner among valid requesters; all low if none valid.
REQ-019 Arbitration SHALL be round-robin: a priority pointer selects the winner on simultaneous requests and toggles to the other requester after every accepted request.
REQ-020 Handshake (valid & ready in IDLE): operands, ctrl and winner index SHALL be registered; IDLE -> EXEC.
REQ-021 alu_src1/alu_src2/alu_ctrl SHALL be driven from the operand registers only, stable throughout EXEC and CAPT, and hold last values in IDLE/RESP.
REQ-022 EXEC -> CAPT unconditionally after one cycle (ALU samples at this edge).
REQ-023 CAPT -> RESP after one cycle, capturing alu_result/zero/cout/overflow into resp_* registers; resp_valid rises with RESP.
REQ-024 Latency: resp_valid SHALL be high exactly 2 cycles after the accepting edge.
REQ-025 RESP: resp_* SHALL hold stable until resp_valid & resp_ready; then RESP -> IDLE, resp_valid low.
REQ-026 req_ready SHALL be low in EXEC, CAPT and RESP; no new request accepted before return to IDLE.
REQ-027 ALU flags SHALL pass through unmodified (cout/overflow 0 for non-add/sub codes).
REQ-028 A requester dropping req_valid before its ready SHALL lose nothing and cause no state change.

Reset
REQ-029 rst_n high SHALL immediately force IDLE, pointer=0, operand registers and alu_ctrl=0, all resp_* and req_ready=0.
REQ-030 Reset during EXEC/CAPT/RESP SHALL discard the in-flight operation; no response issued afterward.

Configuration
REQ-031 With ALU_ARB_STATS_EN defined: outputs grant_cnt0 and grant_cnt1 (16 bits each) SHALL count accepted requests per requester, saturate at 0xFFFF, reset to 0.
REQ-032 Without ALU_ARB_STATS_EN: these ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-033 Package alu_arb_pkg SHALL hold the FSM state enum, DATA_W/CTRL_W defaults and ALU_control constants (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100).
REQ-034 Sub-module rr_arb2 SHALL implement the 2-way round-robin winner selection and pointer; the shared alu instance sits outside this block.

Verification
REQ-035 req0 only, src1=5, src2=3, ctrl=0010 -> resp_valid 2 cycles after accept, result=8, zero=0, resp_id=0.
REQ-036 Both valid after reset, req0 7-7 ctrl=0110, req1 ADD 1+1 -> req0 served first: result=0, zero=1; then req1 result=2, resp_id=1.
REQ-037 req1 0x7FFFFFFF+0x00000001 ctrl=0010 -> result=0x80000000, overflow=1, cout=0.
REQ-038 resp_ready low 5 cycles in RESP -> resp_* stable, req_ready=00 throughout, IDLE one cycle after resp_ready high.
REQ-039 rst_n pulsed during EXEC -> IDLE, resp_valid=0, no response for aborted op; next request served normally.
REQ-040 With ALU_ARB_STATS_EN, 3 grants to req1 -> grant_cnt1=3, grant_cnt0=0; without macro, build succeeds without counter ports.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Optional grant counters are enabled with the ALU_ARB_STATS_EN macro (see alu_arbiter).
package alu_arb_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_CTRL_W = 4;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner selection; the pointer flips on every accepted request.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic ptr;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)        ptr <= 1'b0;
    else if (advance) ptr <= ~ptr;
  end

  // Pointer only matters when both requesters compete.
  always_comb begin
    grant_id = 1'b0;
    case (req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ptr;
      default: grant_id = 1'b0;
    endcase
    grant = (|req_valid) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters: accept, execute, capture, respond.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int CTRL_W = ALU_CTRL_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_src1,
  input  logic [2*DATA_W-1:0] req_src2,
  input  logic [2*CTRL_W-1:0] req_ctrl,
  output logic [DATA_W-1:0]   alu_src1,
  output logic [DATA_W-1:0]   alu_src2,
  output logic [CTRL_W-1:0]   alu_ctrl,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_zero,
  input  logic                alu_cout,
  input  logic                alu_overflow,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_id,
  output logic [DATA_W-1:0]   resp_result,
  output logic                resp_zero,
  output logic                resp_cout,
  output logic                resp_overflow
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]         grant_cnt0,
  output logic [15:0]         grant_cnt1
`endif
);

  arb_state_t state, next_state;
  logic [1:0] grant;
  logic       win_id;
  logic       accept;

  logic [DATA_W-1:0] src1_p0, src2_p0;
  logic [CTRL_W-1:0] ctrl_p0;
  logic              id_p0;

  logic [DATA_W-1:0] result_p1;
  logic              zero_p1, cout_p1, ovf_p1, id_p1;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_id  (win_id)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 2'b00;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst_n ? 2'b00 : grant;
        if (|grant) next_state = EXEC;
      end
      EXEC: next_state = CAPT;
      CAPT: next_state = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // grant is only non-zero for a valid requester, so any ready bit is a handshake
  assign accept = |req_ready;

  // p0: operands latched at the accepting edge, held until the next accept
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      src1_p0 <= '0;
      src2_p0 <= '0;
      ctrl_p0 <= '0;
      id_p0   <= 1'b0;
    end else if (accept) begin
      src1_p0 <= win_id ? req_src1[2*DATA_W-1:DATA_W] : req_src1[DATA_W-1:0];
      src2_p0 <= win_id ? req_src2[2*DATA_W-1:DATA_W] : req_src2[DATA_W-1:0];
      ctrl_p0 <= win_id ? req_ctrl[2*CTRL_W-1:CTRL_W] : req_ctrl[CTRL_W-1:0];
      id_p0   <= win_id;
    end
  end

  assign alu_src1 = src1_p0;
  assign alu_src2 = src2_p0;
  assign alu_ctrl = ctrl_p0;

  // p1: registered ALU outputs captured in CAPT, held through RESP
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      result_p1 <= '0;
      zero_p1   <= 1'b0;
      cout_p1   <= 1'b0;
      ovf_p1    <= 1'b0;
      id_p1     <= 1'b0;
    end else if (state == CAPT) begin
      result_p1 <= alu_result;
      zero_p1   <= alu_zero;
      cout_p1   <= alu_cout;
      ovf_p1    <= alu_overflow;
      id_p1     <= id_p0;
    end
  end

  assign resp_result   = result_p1;
  assign resp_zero     = zero_p1;
  assign resp_cout     = cout_p1;
  assign resp_overflow = ovf_p1;
  assign resp_id       = id_p1;

`ifdef ALU_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (accept) begin
      if (win_id) grant_cnt1 <= sat_inc(grant_cnt1);
      else        grant_cnt0 <= sat_inc(grant_cnt0);
    end
  end
`endif

endmodule
